// File: rtl/data_stack_if.sv
// Command/status bundle between the instruction decoder (master) and the data stack (slave).
interface data_stack_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             PUSH;
  logic             POP;
  logic [WIDTH-1:0] DIN;
  logic [WIDTH-1:0] TOS;
  logic [WIDTH-1:0] NOS;
  logic [CW-1:0]    COUNT;
  logic             EMPTY;
  logic             FULL;
  logic             ERR;

  modport master (
    output PUSH, POP, DIN,
    input  TOS, NOS, COUNT, EMPTY, FULL, ERR
  );

  modport slave (
    input  PUSH, POP, DIN,
    output TOS, NOS, COUNT, EMPTY, FULL, ERR
  );
endinterface

// File: rtl/data_stack.sv
// Operand stack presenting TOS/NOS combinationally; illegal push/pop/replace are suppressed.
// Define DATA_STACK_ERR_EN to build the sticky overflow/underflow ERR flag.
module data_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input logic         CLK,
  input logic         RST,
  data_stack_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic             is_empty;
  logic             is_full;
  logic             do_push;
  logic             do_pop;
  logic             do_repl;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    tos_idx;
  logic [AW-1:0]    nos_idx;

  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_CNT);
  assign tos_idx  = AW'(count - CW'(1));
  assign nos_idx  = AW'(count - CW'(2));

  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_repl = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    unique case ({bus.PUSH, bus.POP})
      2'b10: do_push = !is_full;
      2'b01: do_pop  = !is_empty;
      2'b11: do_repl = !is_empty;
      default: ;
    endcase
    if (do_push) begin
      wr_en  = 1'b1;
      wr_idx = AW'(count);
    end else if (do_repl) begin
      wr_en  = 1'b1;
      wr_idx = tos_idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + CW'(1);
    end else if (do_pop) begin
      count <= count - CW'(1);
    end
  end

  // Storage is never reset; a push coinciding with reset must not land.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) begin
      mem[wr_idx] <= bus.DIN;
    end
  end

`ifdef DATA_STACK_ERR_EN
  logic err;
  logic illegal;

  assign illegal = (bus.PUSH && !bus.POP && is_full) ||
                   (bus.POP && is_empty);

  always_ff @(posedge CLK) begin
    if (RST) begin
      err <= 1'b0;
    end else if (illegal) begin
      err <= 1'b1;
    end
  end

  assign bus.ERR = err;
`else
  assign bus.ERR = 1'b0;
`endif

  assign bus.COUNT = count;
  assign bus.EMPTY = is_empty;
  assign bus.FULL  = is_full;
  assign bus.TOS   = (count >= CW'(1)) ? mem[tos_idx] : '0;
  assign bus.NOS   = (count >= CW'(2)) ? mem[nos_idx] : '0;
endmodule

// File: tb/tb_data_stack.sv
// Directed self-checking bench for data_stack (DEPTH=16, WIDTH=8).
module tb_data_stack;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
`ifdef DATA_STACK_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  data_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic cmd(input logic push, input logic pop, input logic [7:0] din);
    @(negedge CLK);
    bus.PUSH = push;
    bus.POP  = pop;
    bus.DIN  = din;
    @(posedge CLK);
    #1;
    bus.PUSH = 1'b0;
    bus.POP  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) cmd(1'b0, 1'b0, 8'hFF);
    vectors++; if (bus.COUNT !== 5'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", bus.COUNT); end
    vectors++; if (bus.EMPTY !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b exp=1", bus.EMPTY); end
    vectors++; if (bus.FULL !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b exp=0", bus.FULL); end
    vectors++; if (bus.TOS !== 8'h00) begin miscompares++; $display("FAIL reset_tos got=%h exp=00", bus.TOS); end
    vectors++; if (bus.NOS !== 8'h00) begin miscompares++; $display("FAIL reset_nos got=%h exp=00", bus.NOS); end
    vectors++; if (bus.ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", bus.ERR); end
  endtask

  task automatic test_push_pop();
    cmd(1'b1, 1'b0, 8'h11);
    vectors++; if (bus.TOS !== 8'h11 || bus.NOS !== 8'h00) begin miscompares++; $display("FAIL push1 tos=%h nos=%h exp=11/00", bus.TOS, bus.NOS); end
    cmd(1'b1, 1'b0, 8'h22);
    cmd(1'b1, 1'b0, 8'h33);
    vectors++; if (bus.COUNT !== 5'd3) begin miscompares++; $display("FAIL push3_count got=%0d exp=3", bus.COUNT); end
    vectors++; if (bus.TOS !== 8'h33) begin miscompares++; $display("FAIL push3_tos got=%h exp=33", bus.TOS); end
    vectors++; if (bus.NOS !== 8'h22) begin miscompares++; $display("FAIL push3_nos got=%h exp=22", bus.NOS); end
    vectors++; if (bus.EMPTY !== 1'b0) begin miscompares++; $display("FAIL push3_empty got=%b exp=0", bus.EMPTY); end
    cmd(1'b0, 1'b1, 8'hFF);
    vectors++; if (bus.TOS !== 8'h22) begin miscompares++; $display("FAIL pop_tos got=%h exp=22", bus.TOS); end
    vectors++; if (bus.NOS !== 8'h11) begin miscompares++; $display("FAIL pop_nos got=%h exp=11", bus.NOS); end
    vectors++; if (bus.COUNT !== 5'd2) begin miscompares++; $display("FAIL pop_count got=%0d exp=2", bus.COUNT); end
  endtask

  task automatic test_replace();
    cmd(1'b1, 1'b1, 8'h5A);
    vectors++; if (bus.TOS !== 8'h5A) begin miscompares++; $display("FAIL repl_tos got=%h exp=5a", bus.TOS); end
    vectors++; if (bus.NOS !== 8'h11) begin miscompares++; $display("FAIL repl_nos got=%h exp=11", bus.NOS); end
    vectors++; if (bus.COUNT !== 5'd2) begin miscompares++; $display("FAIL repl_count got=%0d exp=2", bus.COUNT); end
    vectors++; if (bus.ERR !== 1'b0) begin miscompares++; $display("FAIL repl_err got=%b exp=0", bus.ERR); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) cmd(1'b1, 1'b0, 8'(i));
    vectors++; if (bus.FULL !== 1'b1) begin miscompares++; $display("FAIL full_flag got=%b exp=1", bus.FULL); end
    vectors++; if (bus.COUNT !== 5'd16) begin miscompares++; $display("FAIL full_count got=%0d exp=16", bus.COUNT); end
    vectors++; if (bus.TOS !== 8'h0F || bus.NOS !== 8'h0E) begin miscompares++; $display("FAIL full_top tos=%h nos=%h exp=0f/0e", bus.TOS, bus.NOS); end
    vectors++; if (bus.ERR !== 1'b0) begin miscompares++; $display("FAIL full_err got=%b exp=0", bus.ERR); end
    cmd(1'b1, 1'b0, 8'hAA);
    vectors++; if (bus.COUNT !== 5'd16) begin miscompares++; $display("FAIL ovf_count got=%0d exp=16", bus.COUNT); end
    vectors++; if (bus.TOS !== 8'h0F) begin miscompares++; $display("FAIL ovf_tos got=%h exp=0f", bus.TOS); end
    vectors++; if (bus.ERR !== ERR_EXP) begin miscompares++; $display("FAIL ovf_err got=%b exp=%b", bus.ERR, ERR_EXP); end
    cmd(1'b1, 1'b1, 8'hBB);
    vectors++; if (bus.TOS !== 8'hBB || bus.NOS !== 8'h0E) begin miscompares++; $display("FAIL full_repl tos=%h nos=%h exp=bb/0e", bus.TOS, bus.NOS); end
    vectors++; if (bus.FULL !== 1'b1) begin miscompares++; $display("FAIL full_repl_full got=%b exp=1", bus.FULL); end
    cmd(1'b0, 1'b1, 8'h00);
    vectors++; if (bus.TOS !== 8'h0E || bus.NOS !== 8'h0D || bus.COUNT !== 5'd15) begin miscompares++; $display("FAIL ovf_pop tos=%h nos=%h cnt=%0d exp=0e/0d/15", bus.TOS, bus.NOS, bus.COUNT); end
  endtask

  task automatic test_underflow();
    do_reset();
    cmd(1'b0, 1'b1, 8'h00);
    vectors++; if (bus.COUNT !== 5'd0 || bus.TOS !== 8'h00) begin miscompares++; $display("FAIL udf_pop cnt=%0d tos=%h exp=0/00", bus.COUNT, bus.TOS); end
    vectors++; if (bus.ERR !== ERR_EXP) begin miscompares++; $display("FAIL udf_pop_err got=%b exp=%b", bus.ERR, ERR_EXP); end
    cmd(1'b1, 1'b1, 8'h44);
    vectors++; if (bus.COUNT !== 5'd0 || bus.TOS !== 8'h00 || bus.EMPTY !== 1'b1) begin miscompares++; $display("FAIL udf_repl cnt=%0d tos=%h empty=%b exp=0/00/1", bus.COUNT, bus.TOS, bus.EMPTY); end
    vectors++; if (bus.ERR !== ERR_EXP) begin miscompares++; $display("FAIL udf_repl_err got=%b exp=%b", bus.ERR, ERR_EXP); end
    cmd(1'b1, 1'b0, 8'h01);
    vectors++; if (bus.COUNT !== 5'd1 || bus.TOS !== 8'h01 || bus.NOS !== 8'h00) begin miscompares++; $display("FAIL udf_push cnt=%0d tos=%h nos=%h exp=1/01/00", bus.COUNT, bus.TOS, bus.NOS); end
    vectors++; if (bus.ERR !== ERR_EXP) begin miscompares++; $display("FAIL err_sticky got=%b exp=%b", bus.ERR, ERR_EXP); end
  endtask

  task automatic test_reset_mid();
    cmd(1'b1, 1'b0, 8'h02);
    cmd(1'b1, 1'b0, 8'h03);
    vectors++; if (bus.COUNT !== 5'd3) begin miscompares++; $display("FAIL mid_pre_count got=%0d exp=3", bus.COUNT); end
    @(negedge CLK);
    RST = 1'b1; bus.PUSH = 1'b1; bus.POP = 1'b0; bus.DIN = 8'h99;
    @(posedge CLK);
    #1;
    RST = 1'b0; bus.PUSH = 1'b0;
    vectors++; if (bus.COUNT !== 5'd0 || bus.EMPTY !== 1'b1) begin miscompares++; $display("FAIL mid_rst cnt=%0d empty=%b exp=0/1", bus.COUNT, bus.EMPTY); end
    vectors++; if (bus.ERR !== 1'b0 || bus.TOS !== 8'h00) begin miscompares++; $display("FAIL mid_rst err=%b tos=%h exp=0/00", bus.ERR, bus.TOS); end
    cmd(1'b1, 1'b0, 8'h77);
    vectors++; if (bus.TOS !== 8'h77 || bus.NOS !== 8'h00 || bus.COUNT !== 5'd1) begin miscompares++; $display("FAIL mid_push tos=%h nos=%h cnt=%0d exp=77/00/1", bus.TOS, bus.NOS, bus.COUNT); end
  endtask

  task automatic test_back_to_back();
    // Held across edges: push, push, replace, pop with no idle cycles in between.
    @(negedge CLK); bus.PUSH = 1'b1; bus.POP = 1'b0; bus.DIN = 8'hC1;
    @(negedge CLK); bus.DIN = 8'hC2;
    @(negedge CLK); bus.POP = 1'b1; bus.DIN = 8'hC3;
    @(negedge CLK); bus.PUSH = 1'b0;
    @(posedge CLK); #1; bus.POP = 1'b0;
    vectors++; if (bus.COUNT !== 5'd2) begin miscompares++; $display("FAIL b2b_count got=%0d exp=2", bus.COUNT); end
    vectors++; if (bus.TOS !== 8'hC1 || bus.NOS !== 8'h77) begin miscompares++; $display("FAIL b2b_top tos=%h nos=%h exp=c1/77", bus.TOS, bus.NOS); end
    cmd(1'b1, 1'b0, 8'hD0);
    vectors++; if (bus.TOS !== 8'hD0 || bus.NOS !== 8'hC1) begin miscompares++; $display("FAIL b2b_overwrite tos=%h nos=%h exp=d0/c1", bus.TOS, bus.NOS); end
  endtask

  initial begin
    bus.PUSH = 1'b0;
    bus.POP  = 1'b0;
    bus.DIN  = '0;
    test_reset();
    test_push_pop();
    test_replace();
    test_overflow();
    test_underflow();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
